// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//
// Word-organised data memory that answers one load/store at a time after a
// fixed number of wait cycles. A request is taken in IDLE. The access is
// latched, the block waits LATENCY cycles in WAIT, and then it answers in
// RESP with a one-cycle ready pulse. Misaligned accesses, illegal formats and
// requests with both enables set are accepted but rejected with a fault
// pulse. They never touch the storage array.
//
// Parameters
//   WORDS   : number of 32-bit storage words (address wraps modulo WORDS)
//   LATENCY : wait cycles between acceptance and response (0..15)
//
// Ports
//   clock                 : single clock, rising-edge
//   reset                 : asynchronous, active-high
//   data_mem_read_enable  : load request
//   data_mem_write_enable : store request
//   address               : byte address of the access
//   write_data            : store data, right-aligned
//   data_format           : funct3 (B, H, W, BU, HU)
//   read_data             : registered, extended load result
//   ready                 : one-cycle response pulse
//   busy                  : high from the cycle after acceptance through RESP
//   fault                 : one-cycle pulse together with ready on rejection
// ---------------------------------------------------------------------------
module dmem_responder #(
    parameter int WORDS   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        data_mem_read_enable,
    input  logic        data_mem_write_enable,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic [2:0]  data_format,
    output logic [31:0] read_data,
    output logic        ready,
    output logic        busy,
    output logic        fault
);

    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int ADR_W = IDX_W + 2;
    localparam logic [3:0] CNT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state;
    state_t            next_state;
    logic [3:0]        count;
    logic [ADR_W-1:0]  addr_q;
    logic [31:0]       wdata_q;
    logic [2:0]        fmt_q;
    logic              store_q;
    logic              fault_q;
    logic [31:0]       mem [WORDS];

    logic              accept;
    logic [ADR_W-1:0]  eff_addr;
    logic [2:0]        eff_fmt;
    logic              eff_store;
    logic              eff_fault;
    logic [31:0]       load_word;
    logic [31:0]       load_shifted;
    logic [31:0]       load_value;
    logic [3:0]        lane_mask;
    logic [31:0]       store_word;

    // Address bits above the word index wrap away.
    logic unused_addr_bits;
    assign unused_addr_bits = ^address[31:ADR_W];

    // Rejection rule. Both enables set, an illegal format, or a misaligned
    // halfword or word access all fault.
    function automatic logic check_fault(input logic re, input logic we,
                                         input logic [1:0] a, input logic [2:0] f);
        logic bad;
        bad = 1'b1;
        case (f)
            3'b000, 3'b100: bad = 1'b0;
            3'b001, 3'b101: bad = a[0];
            3'b010:         bad = (a != 2'b00);
            default:        bad = 1'b1;
        endcase
        return bad | (re & we);
    endfunction

    assign accept = (state == IDLE) && (data_mem_read_enable || data_mem_write_enable);

    // With LATENCY=0 the block enters RESP directly from IDLE. The load result
    // must then come from the live inputs, because the latched copy is not
    // yet valid.
    always_comb begin
        eff_addr  = addr_q;
        eff_fmt   = fmt_q;
        eff_store = store_q;
        eff_fault = fault_q;
        if (state == IDLE) begin
            eff_addr  = address[ADR_W-1:0];
            eff_fmt   = data_format;
            eff_store = data_mem_write_enable & ~data_mem_read_enable;
            eff_fault = check_fault(data_mem_read_enable, data_mem_write_enable,
                                    address[1:0], data_format);
        end
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (accept) next_state = (LATENCY > 0) ? WAIT : RESP;
            WAIT: if (count == 4'd0) next_state = RESP;
            RESP: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        ready = (state == RESP);
        busy  = (state != IDLE);
        fault = (state == RESP) && fault_q;
    end

    // Request latch and wait counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            fmt_q   <= '0;
            store_q <= 1'b0;
            fault_q <= 1'b0;
            count   <= 4'd0;
        end else if (accept) begin
            addr_q  <= address[ADR_W-1:0];
            wdata_q <= write_data;
            fmt_q   <= data_format;
            store_q <= data_mem_write_enable & ~data_mem_read_enable;
            fault_q <= check_fault(data_mem_read_enable, data_mem_write_enable,
                                   address[1:0], data_format);
            count   <= CNT_LOAD;
        end else if (state == WAIT && count != 4'd0) begin
            count <= count - 4'd1;
        end
    end

    // Load path: select the lane and extend it.
    always_comb begin
        load_word    = mem[eff_addr[ADR_W-1:2]];
        load_shifted = load_word >> {eff_addr[1:0], 3'b000};
        case (eff_fmt)
            3'b000:  load_value = {{24{load_shifted[7]}}, load_shifted[7:0]};
            3'b100:  load_value = {24'd0, load_shifted[7:0]};
            3'b001:  load_value = {{16{load_shifted[15]}}, load_shifted[15:0]};
            3'b101:  load_value = {16'd0, load_shifted[15:0]};
            3'b010:  load_value = load_word;
            default: load_value = 32'd0;
        endcase
    end

    // read_data is captured on entry to RESP so that it is valid while ready is
    // high. Store responses leave it alone.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            read_data <= 32'd0;
        end else if (state != RESP && next_state == RESP) begin
            if (eff_fault) begin
                read_data <= 32'd0;
            end else if (!eff_store) begin
                read_data <= load_value;
            end
        end
    end

    // Store lanes and replicated data. Only the enabled lanes are written.
    always_comb begin
        case (fmt_q[1:0])
            2'b00: begin
                lane_mask  = 4'b0001 << addr_q[1:0];
                store_word = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                lane_mask  = addr_q[1] ? 4'b1100 : 4'b0011;
                store_word = {2{wdata_q[15:0]}};
            end
            default: begin
                lane_mask  = 4'b1111;
                store_word = wdata_q;
            end
        endcase
    end

    // The storage array has no reset. A store commits on the edge that ends
    // RESP, so a reset during WAIT or RESP drops the store.
    always_ff @(posedge clock) begin
        if (state == RESP && store_q && !fault_q) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_mask[i]) begin
                    mem[addr_q[ADR_W-1:2]][i*8 +: 8] <= store_word[i*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
//
// Scoreboard bench for dmem_responder. Unit 0 uses LATENCY=2 and unit 1 uses
// LATENCY=0. The reference model is a byte-addressed array with little-endian
// assembly and extension.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

    localparam int WORDS = 256;
    localparam int NBYTES = WORDS * 4;

    typedef struct {
        logic        fault;
        logic        is_load;
        logic [31:0] data;
        int          due;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic        a_re, a_we, b_re, b_we;
    logic [31:0] a_addr, a_wd, b_addr, b_wd;
    logic [2:0]  a_fmt, b_fmt;
    logic [31:0] a_rd, b_rd;
    logic        a_ready, a_busy, a_fault, b_ready, b_busy, b_fault;

    dmem_responder #(.WORDS(WORDS), .LATENCY(2)) dut_a (
        .clock(clock), .reset(reset),
        .data_mem_read_enable(a_re), .data_mem_write_enable(a_we),
        .address(a_addr), .write_data(a_wd), .data_format(a_fmt),
        .read_data(a_rd), .ready(a_ready), .busy(a_busy), .fault(a_fault)
    );

    dmem_responder #(.WORDS(WORDS), .LATENCY(0)) dut_b (
        .clock(clock), .reset(reset),
        .data_mem_read_enable(b_re), .data_mem_write_enable(b_we),
        .address(b_addr), .write_data(b_wd), .data_format(b_fmt),
        .read_data(b_rd), .ready(b_ready), .busy(b_busy), .fault(b_fault)
    );

    exp_t        q_a[$];
    exp_t        q_b[$];
    logic [7:0]  mm [2][NBYTES];
    logic [31:0] last_rd [2];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // Reference model: access size from the format, alignment by modulo,
    // little-endian byte assembly, and sign extension by arithmetic.
    function automatic void model_issue(input int u, input logic re, input logic we,
                                        input logic [31:0] addr, input logic [31:0] wd,
                                        input logic [2:0] fmt, output exp_t e);
        int size;
        int ba;
        logic [31:0] v;
        case (fmt)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            3'd2:       size = 4;
            default:    size = 0;
        endcase
        ba = int'(addr % 32'(NBYTES));
        e.is_load = re && !we;
        e.data    = 32'd0;
        e.due     = 0;
        e.fault   = (re && we) || (size == 0);
        if (size != 0 && (ba % size) != 0) e.fault = 1'b1;
        if (!e.fault) begin
            if (we) begin
                for (int k = 0; k < size; k++) mm[u][ba + k] = wd[k*8 +: 8];
            end else begin
                v = 32'd0;
                for (int k = 0; k < size; k++) v = v | (32'(mm[u][ba + k]) << (8 * k));
                if (fmt == 3'd0 && v[7])  v = v | 32'hFFFFFF00;
                if (fmt == 3'd1 && v[15]) v = v | 32'hFFFF0000;
                e.data = v;
            end
        end
    endfunction

    task automatic applyStimulus(input int u, input logic re, input logic we,
                                 input logic [31:0] addr, input logic [31:0] wd,
                                 input logic [2:0] fmt);
        exp_t e;
        int waited;
        waited = 0;
        @(negedge clock);
        while ((u == 0 ? a_busy : b_busy) && waited < 50) begin
            @(negedge clock);
            waited++;
        end
        if (waited >= 50) begin
            checks++;
            errors++;
            $display("[TB] FAIL idle_wait unit %0d busy=1 required busy=0", u);
        end
        model_issue(u, re, we, addr, wd, fmt, e);
        e.due = cyc + ((u == 0) ? 2 : 0) + 1;
        if (u == 0) begin
            a_re = re; a_we = we; a_addr = addr; a_wd = wd; a_fmt = fmt;
            q_a.push_back(e);
        end else begin
            b_re = re; b_we = we; b_addr = addr; b_wd = wd; b_fmt = fmt;
            q_b.push_back(e);
        end
        @(posedge clock);
        #1;
        if (u == 0) begin a_re = 1'b0; a_we = 1'b0; end
        else begin b_re = 1'b0; b_we = 1'b0; end
    endtask

    task automatic checkOutput(input int u, input logic [31:0] rd,
                               input logic rdy, input logic flt);
        exp_t e;
        logic [31:0] exp_rd;
        if (rdy) begin
            if ((u == 0 && q_a.size() == 0) || (u == 1 && q_b.size() == 0)) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_ready unit %0d got ready=1 required ready=0", u);
            end else begin
                e = (u == 0) ? q_a.pop_front() : q_b.pop_front();
                exp_rd = (e.fault || e.is_load) ? e.data : last_rd[u];
                checks++;
                if (flt !== e.fault) begin
                    errors++;
                    $display("[TB] FAIL fault unit %0d got %0b required %0b", u, flt, e.fault);
                end
                checks++;
                if (rd !== exp_rd) begin
                    errors++;
                    $display("[TB] FAIL read_data unit %0d got %h required %h", u, rd, exp_rd);
                end
                checks++;
                if (cyc != e.due) begin
                    errors++;
                    $display("[TB] FAIL latency unit %0d ready at cycle %0d required %0d", u, cyc, e.due);
                end
                last_rd[u] = exp_rd;
            end
        end
    endtask

    // Monitor: checks every response against the head of the queue.
    always @(negedge clock) begin
        if (!reset) begin
            checkOutput(0, a_rd, a_ready, a_fault);
            checkOutput(1, b_rd, b_ready, b_fault);
        end
    end

    task automatic check_value(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("[TB] FAIL %s got %h required %h", name, got, req);
        end
    endtask

    initial begin
        logic [31:0] addr;
        logic [2:0]  fmt;
        logic        re, we;
        int          kind, r, waited;

        a_re = 0; a_we = 0; a_addr = 0; a_wd = 0; a_fmt = 0;
        b_re = 0; b_we = 0; b_addr = 0; b_wd = 0; b_fmt = 0;
        last_rd[0] = 32'd0;
        last_rd[1] = 32'd0;

        repeat (2) @(negedge clock);
        check_value("reset_ready", 32'(a_ready), 32'd0);
        check_value("reset_busy",  32'(a_busy),  32'd0);
        check_value("reset_fault", 32'(a_fault), 32'd0);
        check_value("reset_rdata", a_rd, 32'd0);
        reset = 1'b0;

        // Give every word in the test region a known value.
        for (int w = 0; w < 16; w++) applyStimulus(0, 1'b0, 1'b1, 32'(w * 4), $urandom, 3'b010);
        for (int w = 0; w < 4; w++)  applyStimulus(1, 1'b0, 1'b1, 32'(w * 4), $urandom, 3'b010);

        $display("[TB] directed accesses");
        applyStimulus(0, 0, 1, 32'h10, 32'hDEADBEEF, 3'b010);
        applyStimulus(0, 1, 0, 32'h10, 32'h0, 3'b010);
        applyStimulus(0, 1, 0, 32'h13, 32'h0, 3'b000);
        applyStimulus(0, 1, 0, 32'h13, 32'h0, 3'b100);
        applyStimulus(0, 1, 0, 32'h12, 32'h0, 3'b001);
        applyStimulus(0, 1, 0, 32'h10, 32'h0, 3'b101);
        applyStimulus(0, 0, 1, 32'h11, 32'h55, 3'b000);
        applyStimulus(0, 1, 0, 32'h10, 32'h0, 3'b010);
        applyStimulus(0, 1, 0, 32'h12, 32'h0, 3'b010);
        applyStimulus(0, 0, 1, 32'h11, 32'hAAAA, 3'b001);
        applyStimulus(0, 1, 0, 32'h10, 32'h0, 3'b010);
        applyStimulus(0, 1, 1, 32'h10, 32'h1111, 3'b010);
        applyStimulus(0, 1, 0, 32'h10, 32'h0, 3'b011);
        applyStimulus(0, 1, 0, 32'h10, 32'h0, 3'b010);

        $display("[TB] reset during WAIT");
        @(negedge clock);
        waited = 0;
        while (a_busy && waited < 50) begin @(negedge clock); waited++; end
        a_we = 1'b1; a_addr = 32'h20; a_wd = 32'h12345678; a_fmt = 3'b010;
        @(posedge clock);
        #1 a_we = 1'b0;
        #1 reset = 1'b1;
        #1;
        check_value("async_ready", 32'(a_ready), 32'd0);
        check_value("async_busy",  32'(a_busy),  32'd0);
        check_value("async_fault", 32'(a_fault), 32'd0);
        check_value("async_rdata", a_rd, 32'd0);
        last_rd[0] = 32'd0;
        last_rd[1] = 32'd0;
        @(negedge clock);
        reset = 1'b0;
        applyStimulus(0, 1, 0, 32'h20, 32'h0, 3'b010);

        $display("[TB] random accesses");
        for (int n = 0; n < 80; n++) begin
            kind = $urandom_range(0, 9);
            re = (kind == 0) || (kind >= 5);
            we = (kind <= 4);
            r = $urandom_range(0, 9);
            case (r)
                0, 1: fmt = 3'b000;
                2:    fmt = 3'b100;
                3:    fmt = 3'b001;
                4:    fmt = 3'b101;
                5, 6: fmt = 3'b010;
                7:    fmt = 3'b011;
                8:    fmt = 3'b110;
                default: fmt = 3'b010;
            endcase
            addr = ($urandom & 32'hFFFFFC00) | 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) begin
                if (fmt == 3'b010) addr[1:0] = 2'b00;
                if (fmt == 3'b001 || fmt == 3'b101) addr[0] = 1'b0;
            end
            applyStimulus(0, re, we, addr, $urandom, fmt);
        end

        $display("[TB] zero-latency back-to-back loads");
        @(negedge clock);
        waited = 0;
        while (b_busy && waited < 50) begin @(negedge clock); waited++; end
        b_addr = 32'h400; b_fmt = 3'b010; b_wd = 32'd0; b_we = 1'b0; b_re = 1'b1;
        for (int i = 0; i < 10; i++) begin
            exp_t e;
            if (i > 0) @(negedge clock);
            check_value("busy_pattern", 32'(b_busy), 32'(i % 2));
            if (!b_busy) begin
                model_issue(1, 1'b1, 1'b0, b_addr, 32'd0, b_fmt, e);
                e.due = cyc + 1;
                q_b.push_back(e);
            end
        end
        @(posedge clock);
        #1 b_re = 1'b0;

        waited = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && waited < 100) begin
            @(negedge clock);
            waited++;
        end
        if (q_a.size() != 0 || q_b.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain pending %0d/%0d required 0/0", q_a.size(), q_b.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
